// File: rtl/fe_framer_pkg.sv
// Shared types, field positions and word builders for the FE trigger framer.
// Imported by the framer top and its output FIFO.
package fe_framer_pkg;

  typedef enum logic {
    ST_PASS,
    ST_STAMP
  } state_t;

  localparam int TRIG_CNT_W = 24;
  localparam int TS_W       = 27;
  localparam int LOST_W     = 8;
  localparam int KIND_BIT   = 27;
  localparam int TRIG_MSB   = 23;
  localparam int TS_MSB     = 26;

  localparam logic [LOST_W-1:0] LOST_SAT = 8'hFF;

  function automatic logic [31:0] mk_header(
    input logic [3:0]            id,
    input logic [TRIG_CNT_W-1:0] num
  );
    logic [31:0] w;
    w              = '0;
    w[31:28]       = id;
    w[KIND_BIT]    = 1'b0;
    w[TRIG_MSB:0]  = num;
    return w;
  endfunction

  function automatic logic [31:0] mk_stamp(
    input logic [3:0]      id,
    input logic [TS_W-1:0] ts
  );
    logic [31:0] w;
    w            = '0;
    w[31:28]     = id;
    w[KIND_BIT]  = 1'b1;
    w[TS_MSB:0]  = ts;
    return w;
  endfunction

endpackage

// File: rtl/fe_framer_out_fifo.sv
// FWFT output buffer for the framer; head word is always on rd_data.
// A write into a full buffer is accepted when a pop happens in the same cycle.
module fe_framer_out_fifo
  import fe_framer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; reset clears contents so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fe_trigger_framer.sv
// Passes FE data words through and inserts a trigger header per trigger.
// Optional timestamp word after each header: FE_FRAMER_TIMESTAMP_EN.
module fe_trigger_framer
  import fe_framer_pkg::*;
#(
  parameter logic [3:0] DATA_IDENTIFIER = 4'b0010,
  parameter int         OUT_DEPTH       = 4
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  ENABLE,
  input  logic                  TRIGGER,
  input  logic                  IN_FIFO_EMPTY,
  input  logic [31:0]           IN_FIFO_DATA,
  output logic                  IN_FIFO_READ,
  input  logic                  OUT_FIFO_READ,
  output logic                  OUT_FIFO_EMPTY,
  output logic [31:0]           OUT_FIFO_DATA,
  output logic [TRIG_CNT_W-1:0] TRIGGER_COUNT,
  output logic [LOST_W-1:0]     LOST_TRIGGER_COUNT
);

  state_t                state;
  state_t                state_nxt;
  logic                  pending;
  logic [TRIG_CNT_W-1:0] pend_num;
  logic [TRIG_CNT_W-1:0] trig_cnt;
  logic [LOST_W-1:0]     lost_cnt;
  logic                  buf_full;
  logic                  space;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic                  hdr_wr;
  logic                  in_rd;
  logic                  accept;

`ifdef FE_FRAMER_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] pend_ts;
  logic [TS_W-1:0] stamp_ts;
`endif

  assign accept = TRIGGER & ENABLE;
  assign space  = ~buf_full | (OUT_FIFO_READ & ~OUT_FIFO_EMPTY);

  assign IN_FIFO_READ       = in_rd;
  assign TRIGGER_COUNT      = trig_cnt;
  assign LOST_TRIGGER_COUNT = lost_cnt;

  // State register.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) state <= ST_PASS;
    else            state <= state_nxt;
  end

  // Header has priority over data; stamp follows the header.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    hdr_wr    = 1'b0;
    in_rd     = 1'b0;
    unique case (state)
      ST_PASS: begin
        if (pending && space) begin
          wr_en   = 1'b1;
          hdr_wr  = 1'b1;
          wr_data = mk_header(DATA_IDENTIFIER, pend_num);
`ifdef FE_FRAMER_TIMESTAMP_EN
          state_nxt = ST_STAMP;
`else
          state_nxt = ST_PASS;
`endif
        end else if (!IN_FIFO_EMPTY && space) begin
          in_rd   = 1'b1;
          wr_en   = 1'b1;
          wr_data = IN_FIFO_DATA;
        end
      end
      ST_STAMP: begin
`ifdef FE_FRAMER_TIMESTAMP_EN
        if (space) begin
          wr_en     = 1'b1;
          wr_data   = mk_stamp(DATA_IDENTIFIER, stamp_ts);
          state_nxt = ST_PASS;
        end
`else
        state_nxt = ST_PASS;
`endif
      end
    endcase
  end

  // Trigger counting; a header write frees the slot for a same-cycle trigger.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      trig_cnt <= '0;
      lost_cnt <= '0;
      pending  <= 1'b0;
      pend_num <= '0;
    end else if (accept) begin
      trig_cnt <= trig_cnt + 1'b1;
      if (!pending || hdr_wr) begin
        pending  <= 1'b1;
        pend_num <= trig_cnt;
      end else if (lost_cnt != LOST_SAT) begin
        lost_cnt <= lost_cnt + 1'b1;
      end
    end else if (hdr_wr) begin
      pending <= 1'b0;
    end
  end

`ifdef FE_FRAMER_TIMESTAMP_EN
  // Free-running cycle counter, sampled on accept, held for the stamp word.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      ts       <= '0;
      pend_ts  <= '0;
      stamp_ts <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (hdr_wr) stamp_ts <= pend_ts;
      if (accept && (!pending || hdr_wr)) pend_ts <= ts;
    end
  end
`endif

  fe_framer_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (32)
  ) u_out_fifo (
    .clk     (BUS_CLK),
    .rst_n   (BUS_RST_N),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (OUT_FIFO_READ),
    .rd_data (OUT_FIFO_DATA),
    .full    (buf_full),
    .empty   (OUT_FIFO_EMPTY)
  );

endmodule

// File: tb/tb_fe_trigger_framer.sv
// Directed bench for fe_trigger_framer: upstream FWFT model, output capture.
// Stamp expectations follow FE_FRAMER_TIMESTAMP_EN when defined.
module tb_fe_trigger_framer;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        TRIGGER = 1'b0;
  logic        OUT_FIFO_READ = 1'b0;
  logic        IN_FIFO_READ;
  logic        OUT_FIFO_EMPTY;
  logic [31:0] OUT_FIFO_DATA;
  logic [23:0] TRIGGER_COUNT;
  logic [7:0]  LOST_TRIGGER_COUNT;

  logic [31:0] up_mem [64];
  int          up_wr = 0;
  int          up_rd = 0;
  logic        in_empty;
  logic [31:0] in_data;

  int          rd_cycles = 0;
  int          rd_viol = 0;
  logic [31:0] cap [256];
  int          out_n = 0;

  logic [31:0] exp_w [32];
  bit          exp_st [32];
  int          exp_n;
  int          base;
  int          rdb;
  int          n_chk = 0;
  int          n_pass = 0;

  assign in_empty = (up_rd == up_wr);
  assign in_data  = up_mem[up_rd[5:0]];

  always #5 BUS_CLK = ~BUS_CLK;

  fe_trigger_framer dut (
    .BUS_CLK            (BUS_CLK),
    .BUS_RST_N          (BUS_RST_N),
    .ENABLE             (ENABLE),
    .TRIGGER            (TRIGGER),
    .IN_FIFO_EMPTY      (in_empty),
    .IN_FIFO_DATA       (in_data),
    .IN_FIFO_READ       (IN_FIFO_READ),
    .OUT_FIFO_READ      (OUT_FIFO_READ),
    .OUT_FIFO_EMPTY     (OUT_FIFO_EMPTY),
    .OUT_FIFO_DATA      (OUT_FIFO_DATA),
    .TRIGGER_COUNT      (TRIGGER_COUNT),
    .LOST_TRIGGER_COUNT (LOST_TRIGGER_COUNT)
  );

  always @(posedge BUS_CLK) begin
    if (IN_FIFO_READ) begin
      rd_cycles <= rd_cycles + 1;
      if (in_empty) rd_viol <= rd_viol + 1;
      else          up_rd   <= up_rd + 1;
    end
  end

  always @(posedge BUS_CLK) begin
    if (OUT_FIFO_READ && !OUT_FIFO_EMPTY) begin
      cap[out_n[7:0]] <= OUT_FIFO_DATA;
      out_n           <= out_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic push_up(input logic [31:0] w);
    up_mem[up_wr[5:0]] = w;
    up_wr++;
  endtask

  task automatic exp_clear();
    exp_n = 0;
    base  = out_n;
  endtask

  task automatic exp_data(input logic [31:0] w);
    exp_w[exp_n]  = w;
    exp_st[exp_n] = 1'b0;
    exp_n++;
  endtask

  task automatic exp_hdr(input logic [23:0] num);
    exp_data({4'b0010, 4'b0000, num});
`ifdef FE_FRAMER_TIMESTAMP_EN
    exp_w[exp_n]  = 32'h2800_0000;
    exp_st[exp_n] = 1'b1;
    exp_n++;
`endif
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, out_n - base, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (exp_st[i])
        chk($sformatf("%s_stamp%0d", tag, i),
            {cap[(base + i) % 256][31:27], 27'd0}, exp_w[i]);
      else
        chk($sformatf("%s_w%0d", tag, i), cap[(base + i) % 256], exp_w[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge BUS_CLK);
    BUS_RST_N     = 1'b0;
    TRIGGER       = 1'b0;
    OUT_FIFO_READ = 1'b0;
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
  endtask

  task automatic pulse();
    TRIGGER = 1'b1;
    @(negedge BUS_CLK);
    TRIGGER = 1'b0;
    @(negedge BUS_CLK);
  endtask

  initial begin
    tick(2);
    chk("rst_empty", OUT_FIFO_EMPTY, 1);
    chk("rst_data", OUT_FIFO_DATA, 0);
    chk("rst_inrd", IN_FIFO_READ, 0);
    BUS_RST_N = 1'b1;
    tick(2);
    chk("idle_empty", OUT_FIFO_EMPTY, 1);
    chk("idle_tcnt", TRIGGER_COUNT, 0);
    chk("idle_lost", LOST_TRIGGER_COUNT, 0);
    chk("idle_inrd", IN_FIFO_READ, 0);

    OUT_FIFO_READ = 1'b1;
    exp_clear();
    rdb = rd_cycles;
    for (int i = 1; i <= 5; i++) begin
      push_up(i);
      exp_data(i);
    end
    #1;
    chk("lat_inrd", IN_FIFO_READ, 1);
    chk("lat_pre_empty", OUT_FIFO_EMPTY, 1);
    @(negedge BUS_CLK);
    chk("lat_empty", OUT_FIFO_EMPTY, 0);
    chk("lat_data", OUT_FIFO_DATA, 32'h1);
    tick(8);
    chk_stream("pass");
    chk("pass_rdcyc", rd_cycles - rdb, 5);

    ENABLE = 1'b1;
    exp_clear();
    for (int i = 1; i <= 5; i++) push_up(i);
    exp_data(1);
    exp_data(2);
    exp_hdr(24'h0);
    exp_data(3);
    exp_data(4);
    exp_data(5);
    @(negedge BUS_CLK);
    TRIGGER = 1'b1;
    @(negedge BUS_CLK);
    TRIGGER = 1'b0;
    tick(10);
    chk_stream("trig");
    chk("trig_tcnt", TRIGGER_COUNT, 1);
    chk("trig_lost", LOST_TRIGGER_COUNT, 0);

    do_reset();
    ENABLE = 1'b1;
    for (int i = 0; i < 5; i++) push_up(32'h11 + i);
    tick(6);
    chk("stall_inrd", IN_FIFO_READ, 0);
    chk("stall_head", OUT_FIFO_DATA, 32'h11);
    TRIGGER = 1'b1;
    @(negedge BUS_CLK);
    TRIGGER = 1'b0;
    @(negedge BUS_CLK);
    TRIGGER = 1'b1;
    @(negedge BUS_CLK);
    TRIGGER = 1'b0;
    tick(2);
    chk("stall_tcnt", TRIGGER_COUNT, 2);
    chk("stall_lost", LOST_TRIGGER_COUNT, 1);
    chk("stall_head2", OUT_FIFO_DATA, 32'h11);
    exp_clear();
    for (int i = 0; i < 4; i++) exp_data(32'h11 + i);
    exp_hdr(24'h0);
    exp_data(32'h15);
    OUT_FIFO_READ = 1'b1;
    tick(10);
    chk_stream("stall");

    do_reset();
    ENABLE        = 1'b0;
    OUT_FIFO_READ = 1'b1;
    exp_clear();
    push_up(32'hA1);
    push_up(32'hA2);
    exp_data(32'hA1);
    exp_data(32'hA2);
    repeat (10) pulse();
    tick(4);
    chk_stream("dis");
    chk("dis_tcnt", TRIGGER_COUNT, 0);

    do_reset();
    ENABLE        = 1'b1;
    OUT_FIFO_READ = 1'b1;
    force dut.trig_cnt = 24'hFFFFFF;
    @(negedge BUS_CLK);
    release dut.trig_cnt;
    @(negedge BUS_CLK);
    chk("wrap_preload", TRIGGER_COUNT, 24'hFFFFFF);
    exp_clear();
    exp_hdr(24'hFFFFFF);
    exp_hdr(24'h000000);
    pulse();
    tick(4);
    pulse();
    tick(4);
    chk_stream("wrap");
    chk("wrap_tcnt", TRIGGER_COUNT, 1);

    OUT_FIFO_READ = 1'b0;
    for (int i = 0; i < 4; i++) push_up(32'h31 + i);
    tick(6);
    TRIGGER = 1'b1;
    repeat (300) @(negedge BUS_CLK);
    TRIGGER = 1'b0;
    tick(1);
    chk("sat_lost", LOST_TRIGGER_COUNT, 255);
    chk("sat_tcnt", TRIGGER_COUNT, 301);

    do_reset();
    ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) push_up(32'h41 + i);
    pulse();
    tick(6);
    chk("arst_pre_empty", OUT_FIFO_EMPTY, 0);
    chk("arst_pre_tcnt", TRIGGER_COUNT, 1);
    #2;
    BUS_RST_N = 1'b0;
    #1;
    chk("arst_empty", OUT_FIFO_EMPTY, 1);
    chk("arst_data", OUT_FIFO_DATA, 0);
    chk("arst_tcnt", TRIGGER_COUNT, 0);
    chk("arst_lost", LOST_TRIGGER_COUNT, 0);
    chk("arst_inrd", IN_FIFO_READ, 0);
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    tick(2);
    chk("rd_when_empty", rd_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fe_trigger_framer.md
# fe_trigger_framer

Stream stage between the FE-RX data FIFO and the round-robin arbiter in the FE65-P2 MIO readout. It pops 32-bit FE data words and passes them through unchanged. On each accepted trigger pulse it inserts a header word carrying a trigger number, so offline analysis can split the stream into events. It presents a first-word-fall-through (FWFT) FIFO interface to the arbiter, identical in style to the FE-RX and TDC FIFO ports.

## Interface
- DATA_IDENTIFIER, 4'b0010: value placed in bits [31:28] of every inserted word.
- OUT_DEPTH, 4: output buffer depth in words; power of two, minimum 2.
- BUS_CLK  in  1  sole clock.
- BUS_RST_N  in  1  reset, asynchronous assert, active-low. One clock; asynchronous active-low reset, as decided.
- ENABLE  in  1  level; 0 = triggers ignored, data still passes.
- TRIGGER  in  1  single-cycle pulse, already synchronous to BUS_CLK.
- IN_FIFO_EMPTY  in  1  upstream FWFT empty flag.
- IN_FIFO_DATA  in  32  upstream head word; valid while IN_FIFO_EMPTY=0.
- IN_FIFO_READ  out  1  pops the upstream head word this cycle.
- OUT_FIFO_READ  in  1  arbiter pops the output head word.
- OUT_FIFO_EMPTY  out  1  output buffer empty.
- OUT_FIFO_DATA  out  32  output head word, FWFT.
- TRIGGER_COUNT  out  24  triggers accepted since reset; wraps.
- LOST_TRIGGER_COUNT  out  8  triggers merged into a pending header; saturates at 255.

## Operation
- Accepted trigger: TRIGGER=1 and ENABLE=1. Each accepted trigger increments TRIGGER_COUNT, wrapping 0xFFFFFF->0.
- Pending header:
  - If no header is pending, an accepted trigger latches pend_num = current TRIGGER_COUNT (pre-increment value) and sets pending.
  - If a header is already pending, the accepted trigger only increments LOST_TRIGGER_COUNT. No second header is produced.
- Header word: {DATA_IDENTIFIER, 1'b0, 3'b000, pend_num[23:0]}.
- FSM states:
  - PASS: if pending and the buffer is not full, write the header and go to STAMP. With the timestamp feature compiled out, go back to PASS instead.
  - Otherwise in PASS: if IN_FIFO_EMPTY=0 and the buffer is not full, assert IN_FIFO_READ and write IN_FIFO_DATA unchanged.
  - STAMP: if the buffer is not full, write the timestamp word and go to PASS.
- Priority: a pending header is always written before the next data word. Data is never reordered.
- IN_FIFO_READ is combinational from state, pending, buffer-full and IN_FIFO_EMPTY. It is never asserted while IN_FIFO_EMPTY=1 or while the buffer is full.
- Simultaneous accepted trigger and header write in the same cycle: the header carries the old pend_num, and pending is re-armed with the new number. Not counted as lost.
- Simultaneous write and OUT_FIFO_READ on a full buffer: write permitted. Full is evaluated after the read.
- OUT_FIFO_READ while OUT_FIFO_EMPTY=1: ignored, no underflow.
- ENABLE falling while pending: the already-pending header is still emitted.

## Timing
- Reset values: OUT_FIFO_EMPTY=1, OUT_FIFO_DATA=0, IN_FIFO_READ=0, TRIGGER_COUNT=0, LOST_TRIGGER_COUNT=0. Pending cleared, state PASS, buffer emptied, timestamp=0.
- Reset mid-operation discards all buffered and pending content immediately.
- Latency:
  - Upstream pop in cycle N -> word visible at OUT_FIFO_DATA, OUT_FIFO_EMPTY=0, in cycle N+1 when the buffer was empty.
  - TRIGGER in cycle N -> header written at the earliest in cycle N+1.
- Throughput: one word per cycle. Each header costs one cycle, and each timestamp word one more.
- OUT_FIFO_DATA changes only on a pop, or on a write into an empty buffer.

## Configuration
- FE_FRAMER_TIMESTAMP_EN defined:
  - A 27-bit free-running BUS_CLK cycle counter is sampled at trigger acceptance.
  - STAMP emits {DATA_IDENTIFIER, 1'b1, ts[26:0]} immediately after each header.
  - The counter wraps 0x7FFFFFF->0.
- Undefined: no counter, STAMP unreachable, header only.

## Structure
- Package fe_framer_pkg holds:
  - the FSM state enum;
  - header/stamp bit positions: kind bit 27, trigger field [23:0], timestamp field [26:0];
  - TRIG_CNT_W=24 and TS_W=27;
  - the LOST_TRIGGER_COUNT saturation value.
- One sub-module: fe_framer_out_fifo, a synchronous FWFT FIFO, OUT_DEPTH x 32, with full/empty flags and async active-low reset.

## Test plan
- Reset, no stimulus -> OUT_FIFO_EMPTY=1, both counters 0, IN_FIFO_READ=0.
- Upstream words 0x00000001..0x00000005, no trigger, OUT_FIFO_READ held 1 -> same five words in order, 1-cycle latency, IN_FIFO_READ high 5 cycles.
- ENABLE=1, TRIGGER pulse mid-stream after word 2 -> output 1, 2, 0x20000000, 3, 4, 5; TRIGGER_COUNT=1. With FE_FRAMER_TIMESTAMP_EN, a stamp word with bit 27=1 follows the header.
- Two TRIGGER pulses 1 cycle apart while the output is stalled (OUT_FIFO_READ=0, buffer full) -> one header with number 0, TRIGGER_COUNT=2, LOST_TRIGGER_COUNT=1.
- ENABLE=0 with 10 TRIGGER pulses -> no headers, TRIGGER_COUNT=0.
- Preload TRIGGER_COUNT to 0xFFFFFF via a force, trigger twice with drain between -> header numbers 0xFFFFFF then 0x000000. 300 stalled triggers -> LOST_TRIGGER_COUNT=255.
- BUS_RST_N pulsed low with 3 words buffered -> OUT_FIFO_EMPTY=1 asynchronously, counters 0.
